// File: rtl/tone_voice_sequencer.sv
// Time-multiplexed phase-accumulator scheduler: one shared adder walks every voice once per
// sample_tick, applies hard-sync, and streams per-voice slots; config writes commit between frames.
module tone_voice_sequencer #(
  parameter int VOICES           = 4,
  parameter int FREQ_BITS        = 16,
  parameter int PULSEWIDTH_BITS  = 12,
  parameter int ACCUMULATOR_BITS = 24,
  localparam int VW = $clog2(VOICES)
) (
  input  logic                        main_clk,
  input  logic                        rst_n,
  input  logic                        sample_tick,
  input  logic                        cfg_wr,
  input  logic [VW-1:0]               cfg_voice,
  input  logic [1:0]                  cfg_addr,
  input  logic [15:0]                 cfg_data,
  output logic                        cfg_ready,
  output logic                        slot_valid,
  output logic [VW-1:0]               slot_voice,
  output logic [ACCUMULATOR_BITS-1:0] slot_acc,
  output logic [PULSEWIDTH_BITS-1:0]  slot_pw,
  output logic [5:0]                  slot_ctrl,
  output logic                        slot_ring_src,
  output logic                        frame_done,
  output logic                        overrun
);
  localparam int A = ACCUMULATOR_BITS;
  localparam logic [VW-1:0] LAST = VW'(VOICES - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e              state_q, state_d;
  logic [VW-1:0]       idx_q, idx_d, prev_idx;
  logic                commit, step, cfg_accept, sync_hit;
  logic [A:0]          sum;

  logic                pend_q;
  logic [VW-1:0]       pend_voice_q;
  logic [1:0]          pend_addr_q;
  logic [15:0]         pend_data_q;

  logic [A-1:0]                 acc_q  [VOICES];
  logic                         ovf_q  [VOICES];
  logic [FREQ_BITS-1:0]         freq_q [VOICES];
  logic [PULSEWIDTH_BITS-1:0]   pw_q   [VOICES];
  logic [5:0]                   ctrl_q [VOICES];

  logic                         slot_valid_q, frame_done_q, overrun_q, ring_q;
  logic [VW-1:0]                slot_voice_q;
  logic [A-1:0]                 slot_acc_q;
  logic [PULSEWIDTH_BITS-1:0]   slot_pw_q;
  logic [5:0]                   slot_ctrl_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    commit  = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        // Commit and tick may coincide; the frame then sees the committed value.
        commit = pend_q;
        if (sample_tick) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        step = 1'b1;
        if (idx_q == LAST) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign prev_idx   = (idx_q == '0) ? LAST : idx_q - 1'b1;
  assign sum        = {1'b0, acc_q[idx_q]} + (A + 1)'(freq_q[idx_q]);
  assign sync_hit   = ctrl_q[idx_q][5] && ovf_q[prev_idx];
  assign cfg_accept = cfg_wr && !pend_q;

  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      overrun_q    <= 1'b0;
      pend_q       <= 1'b0;
      pend_voice_q <= '0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (sample_tick && state_q == RUN) overrun_q <= 1'b1;
      if (cfg_accept) begin
        pend_q       <= 1'b1;
        pend_voice_q <= cfg_voice;
        pend_addr_q  <= cfg_addr;
        pend_data_q  <= cfg_data;
      end else if (commit) begin
        pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < VOICES; v++) begin
        freq_q[v] <= '0;
        pw_q[v]   <= '0;
        ctrl_q[v] <= '0;
      end
    end else if (commit) begin
      case (pend_addr_q)
        2'd0:    freq_q[pend_voice_q] <= FREQ_BITS'(pend_data_q);
        2'd1:    pw_q[pend_voice_q]   <= PULSEWIDTH_BITS'(pend_data_q);
        2'd2:    ctrl_q[pend_voice_q] <= 6'(pend_data_q);
        default: ;
      endcase
    end
  end

  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < VOICES; v++) begin
        acc_q[v] <= '0;
        ovf_q[v] <= 1'b0;
      end
    end else if (step) begin
      acc_q[idx_q] <= sync_hit ? '0 : sum[A-1:0];
      ovf_q[idx_q] <= sync_hit ? 1'b0 : sum[A];
    end
  end

  // Slot outputs hold their last value between slots; only slot_valid/frame_done pulse.
  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      slot_voice_q <= '0;
      slot_acc_q   <= '0;
      slot_pw_q    <= '0;
      slot_ctrl_q  <= '0;
      ring_q       <= 1'b0;
    end else begin
      slot_valid_q <= step;
      frame_done_q <= step && (idx_q == LAST);
      if (step) begin
        slot_voice_q <= idx_q;
        slot_acc_q   <= sync_hit ? '0 : sum[A-1:0];
        slot_pw_q    <= pw_q[idx_q];
        slot_ctrl_q  <= ctrl_q[idx_q];
        ring_q       <= acc_q[prev_idx][A-1];
      end
    end
  end

  assign cfg_ready     = !pend_q;
  assign slot_valid    = slot_valid_q;
  assign slot_voice    = slot_voice_q;
  assign slot_acc      = slot_acc_q;
  assign slot_pw       = slot_pw_q;
  assign slot_ctrl     = slot_ctrl_q;
  assign slot_ring_src = ring_q;
  assign frame_done    = frame_done_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_tone_voice_sequencer.sv
// Directed bench for tone_voice_sequencer: a behavioural voice model fills a slot scoreboard at
// each tick; a negedge monitor pops and compares every slot the DUT emits.
module tb_tone_voice_sequencer;
  localparam int NV = 4;

  logic        main_clk = 1'b0;
  logic        rst_n, sample_tick, cfg_wr;
  logic [1:0]  cfg_voice, cfg_addr;
  logic [15:0] cfg_data;
  logic        cfg_ready, slot_valid, slot_ring_src, frame_done, overrun;
  logic [1:0]  slot_voice;
  logic [23:0] slot_acc;
  logic [11:0] slot_pw;
  logic [5:0]  slot_ctrl;

  tone_voice_sequencer #(
    .VOICES(NV), .FREQ_BITS(16), .PULSEWIDTH_BITS(12), .ACCUMULATOR_BITS(24)
  ) dut (
    .main_clk(main_clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .cfg_wr(cfg_wr), .cfg_voice(cfg_voice), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .slot_valid(slot_valid), .slot_voice(slot_voice),
    .slot_acc(slot_acc), .slot_pw(slot_pw), .slot_ctrl(slot_ctrl),
    .slot_ring_src(slot_ring_src), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 main_clk = ~main_clk;

  typedef struct packed {
    logic [1:0]  voice;
    logic [23:0] acc;
    logic [11:0] pw;
    logic [5:0]  ctrl;
    logic        ring;
    logic        done;
  } slot_t;

  slot_t       sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          slot_cnt = 0;

  logic [23:0] m_acc  [NV];
  logic        m_ovf  [NV];
  logic [15:0] m_freq [NV];
  logic [11:0] m_pw   [NV];
  logic [5:0]  m_ctrl [NV];
  logic [23:0] cap_acc [NV];
  logic [11:0] cap_pw  [NV];
  logic [5:0]  cap_ctrl[NV];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [48:0] outs();
    return {cfg_ready, slot_valid, slot_voice, slot_acc, slot_pw, slot_ctrl,
            slot_ring_src, frame_done, overrun};
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_acc[v] = '0; m_ovf[v] = 1'b0; m_freq[v] = '0; m_pw[v] = '0; m_ctrl[v] = '0;
    end
  endtask

  task automatic model_frame();
    logic [24:0] s;
    int          p;
    slot_t       e;
    for (int v = 0; v < NV; v++) begin
      p = (v + NV - 1) % NV;
      s = {1'b0, m_acc[v]} + {9'd0, m_freq[v]};
      if (m_ctrl[v][5] && m_ovf[p]) begin
        m_acc[v] = '0;
        m_ovf[v] = 1'b0;
      end else begin
        m_acc[v] = s[23:0];
        m_ovf[v] = s[24];
      end
      e.voice = 2'(v);
      e.acc   = m_acc[v];
      e.pw    = m_pw[v];
      e.ctrl  = m_ctrl[v];
      e.ring  = m_acc[p][23];
      e.done  = (v == NV - 1);
      sb.push_back(e);
    end
  endtask

  task automatic cfg_write(input int v, input int a, input logic [15:0] d);
    int n = 0;
    while (!cfg_ready && n < 20) begin
      @(posedge main_clk); #1;
      n++;
    end
    chk("cfg_ready_wait", cfg_ready, 1);
    cfg_wr = 1'b1; cfg_voice = 2'(v); cfg_addr = 2'(a); cfg_data = d;
    @(posedge main_clk); #1;
    cfg_wr = 1'b0;
    case (a)
      0: m_freq[v] = d;
      1: m_pw[v]   = d[11:0];
      2: m_ctrl[v] = d[5:0];
      default: ;
    endcase
  endtask

  task automatic tick_frame(input string tag);
    sample_tick = 1'b1;
    model_frame();
    @(posedge main_clk); #1;
    sample_tick = 1'b0;
    chk({tag, "_pre_valid"}, slot_valid, 0);
    for (int k = 0; k < NV; k++) begin
      @(posedge main_clk); #1;
      chk({tag, "_valid"}, slot_valid, 1);
      chk({tag, "_voice"}, slot_voice, k);
      chk({tag, "_done"}, frame_done, (k == NV - 1));
      cap_acc[k]  = slot_acc;
      cap_pw[k]   = slot_pw;
      cap_ctrl[k] = slot_ctrl;
    end
    @(posedge main_clk); #1;
    chk({tag, "_post_valid"}, slot_valid, 0);
    chk({tag, "_post_done"}, frame_done, 0);
  endtask

  task automatic tick_fast();
    sample_tick = 1'b1;
    model_frame();
    @(posedge main_clk); #1;
    sample_tick = 1'b0;
    repeat (NV) @(posedge main_clk);
    #1;
  endtask

  always @(negedge main_clk) begin
    if (rst_n === 1'b1) begin
      if (slot_valid === 1'b1) begin
        slot_cnt++;
        chk("slot_expected", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          slot_t e;
          e = sb.pop_front();
          chk("mon_voice", slot_voice, e.voice);
          chk("mon_acc", slot_acc, e.acc);
          chk("mon_pw", slot_pw, e.pw);
          chk("mon_ctrl", slot_ctrl, e.ctrl);
          chk("mon_ring", slot_ring_src, e.ring);
          chk("mon_done", frame_done, e.done);
        end
      end else begin
        chk("mon_idle_done", frame_done, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    rst_n = 1'b0; sample_tick = 1'b0; cfg_wr = 1'b0;
    cfg_voice = '0; cfg_addr = '0; cfg_data = '0;
    model_reset();
    repeat (3) @(posedge main_clk);
    #1;
    chk("in_reset_outs", outs(), {1'b1, 48'd0});
    rst_n = 1'b1;

    // Reset state, no ticks
    for (int i = 0; i < 20; i++) begin
      @(posedge main_clk); #1;
      chk("reset_outs", outs(), {1'b1, 48'd0});
    end

    // Frame timing and accumulation
    for (int v = 0; v < NV; v++) cfg_write(v, 0, 16'(v + 1));
    tick_frame("t2a");
    for (int v = 0; v < NV; v++) chk("t2a_acc", cap_acc[v], v + 1);
    tick_frame("t2b");
    for (int v = 0; v < NV; v++) chk("t2b_acc", cap_acc[v], 2 * (v + 1));

    // Field truncation and reserved address
    cfg_write(1, 1, 16'hFABC);
    cfg_write(2, 2, 16'hFF0E);
    cfg_write(0, 3, 16'h7777);
    tick_frame("t2c");
    chk("t2c_pw1", cap_pw[1], 12'hABC);
    chk("t2c_ctrl2", cap_ctrl[2], 6'h0E);
    chk("t2c_acc0_reserved", cap_acc[0], 24'd3);

    // Config hazard: write lands during RUN
    sample_tick = 1'b1;
    model_frame();
    @(posedge main_clk); #1;
    sample_tick = 1'b0;
    chk("t4_ready_first", cfg_ready, 1);
    cfg_wr = 1'b1; cfg_voice = 2'd2; cfg_addr = 2'd0; cfg_data = 16'h0100;
    m_freq[2] = 16'h0100;
    @(posedge main_clk); #1;
    cfg_voice = 2'd3; cfg_data = 16'h0055;
    chk("t4_ready_stall", cfg_ready, 0);
    chk("t4_voice0", slot_voice, 0);
    for (int k = 1; k < NV; k++) begin
      @(posedge main_clk); #1;
      chk("t4_ready_stall", cfg_ready, 0);
      chk("t4_voice", slot_voice, k);
      if (k == 2) chk("t4_acc2_old_freq", slot_acc, 24'd12);
    end
    @(posedge main_clk); #1;
    chk("t4_ready_drained", cfg_ready, 1);
    chk("t4_idle_valid", slot_valid, 0);
    @(posedge main_clk); #1;
    cfg_wr = 1'b0;
    chk("t4_second_accepted", cfg_ready, 0);
    m_freq[3] = 16'h0055;
    tick_frame("t4b");
    chk("t4b_acc2", cap_acc[2], 24'h10C);
    chk("t4b_acc3", cap_acc[3], 24'h65);

    // Overrun
    cnt0 = slot_cnt;
    sample_tick = 1'b1;
    model_frame();
    @(posedge main_clk); #1;
    sample_tick = 1'b0;
    chk("t5_overrun_before", overrun, 0);
    @(posedge main_clk); #1;
    sample_tick = 1'b1;
    @(posedge main_clk); #1;
    sample_tick = 1'b0;
    chk("t5_overrun_set", overrun, 1);
    repeat (8) @(posedge main_clk);
    #1;
    chk("t5_overrun_sticky", overrun, 1);
    chk("t5_slot_count", slot_cnt - cnt0, 4);

    // Reset mid-frame
    sample_tick = 1'b1;
    model_frame();
    @(posedge main_clk); #1;
    sample_tick = 1'b0;
    @(posedge main_clk); #1;
    @(posedge main_clk); #1;
    chk("t6_voice1_slot", {slot_valid, slot_voice}, 3'b101);
    rst_n = 1'b0;
    #1;
    chk("t6_async_outs", outs(), {1'b1, 48'd0});
    sb.delete();
    model_reset();
    repeat (3) @(posedge main_clk);
    #1;
    rst_n = 1'b1;
    cnt0 = slot_cnt;
    repeat (8) @(posedge main_clk);
    #1;
    chk("t6_no_partial_slot", slot_cnt - cnt0, 0);
    cfg_write(0, 0, 16'hC030);
    cfg_write(1, 0, 16'h0101);
    cfg_write(2, 0, 16'h1234);
    cfg_write(3, 0, 16'h0008);
    tick_frame("t6");
    chk("t6_acc0", cap_acc[0], 24'h00C030);
    chk("t6_acc1", cap_acc[1], 24'h000101);
    chk("t6_acc2", cap_acc[2], 24'h001234);
    chk("t6_acc3", cap_acc[3], 24'h000008);

    // Wrap and hard-sync: 341 * 0xC030 = 0xFFFFF0
    repeat (340) tick_fast();
    cfg_write(0, 0, 16'h0020);
    cfg_write(1, 2, 16'h0020);
    tick_frame("t3a");
    chk("t3a_acc0_wrap", cap_acc[0], 24'h000010);
    chk("t3a_acc1_sync", cap_acc[1], 24'h000000);
    tick_frame("t3b");
    chk("t3b_acc0", cap_acc[0], 24'h000030);
    chk("t3b_acc1_nosync", cap_acc[1], 24'h000101);

    repeat (3) @(posedge main_clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
